vaddsub_issue: RTL and testbench

VADDSUB_ISSUE -- requirements
Module: vaddsub_issue

---
 rtl/vaddsub_issue.sv | 167 ++++++++++++++++
 tb/tb_vaddsub_issue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vaddsub_issue.sv
// Two-stage issue stage for vector add/sub: decode into S1, capture the external adder result in S2.
// Optional VADDSUB_MASK_EN adds per-element mask (in_vm) and old-destination (in_vd) merging.
`ifndef VLEN
`define VLEN 128
`endif

module vaddsub_issue #(
    parameter int VLEN_P = `VLEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [2:0]          in_sew,
    input  logic [VLEN_P-1:0]   in_vs1,
    input  logic [VLEN_P-1:0]   in_vs2,
`ifdef VADDSUB_MASK_EN
    input  logic [VLEN_P/8-1:0] in_vm,
    input  logic [VLEN_P-1:0]   in_vd,
`endif
    output logic                add_ctrl,
    output logic                add_sew_16_32,
    output logic                add_sew_32,
    output logic [VLEN_P-1:0]   add_a,
    output logic [VLEN_P-1:0]   add_b,
    input  logic [VLEN_P-1:0]   add_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [VLEN_P-1:0]   out_data,
    output logic                out_err,
    output logic [15:0]         op_count
);

    localparam int NBYTES = VLEN_P / 8;

    logic              s1_valid, s1_ready, s1_ctrl, s1_sew_16_32, s1_sew_32, s1_err;
    logic [VLEN_P-1:0] s1_a, s1_b;
    logic              s2_valid, s2_ready, s2_err;
    logic [VLEN_P-1:0] s2_data;

    logic              dec_ctrl, dec_sew_16_32, dec_sew_32, dec_err;
    logic [VLEN_P-1:0] dec_a, dec_b;
    logic [VLEN_P-1:0] merged;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;

    // Illegal requests still flow through, but with zeroed operands and the error flag set.
    always_comb begin
        dec_ctrl      = 1'b0;
        dec_sew_16_32 = 1'b0;
        dec_sew_32    = 1'b0;
        dec_a         = in_vs2;
        dec_b         = in_vs1;
        dec_err       = (in_op == 2'b11) || (in_sew > 3'b010);
        case (in_op)
            2'b01:   dec_ctrl = 1'b1;
            2'b10: begin
                dec_ctrl = 1'b1;
                dec_a    = in_vs1;
                dec_b    = in_vs2;
            end
            default: dec_ctrl = 1'b0;
        endcase
        case (in_sew)
            3'b001:  dec_sew_16_32 = 1'b1;
            3'b010: begin
                dec_sew_16_32 = 1'b1;
                dec_sew_32    = 1'b1;
            end
            default: dec_sew_16_32 = 1'b0;
        endcase
        if (dec_err) begin
            dec_ctrl      = 1'b0;
            dec_sew_16_32 = 1'b0;
            dec_sew_32    = 1'b0;
            dec_a         = '0;
            dec_b         = '0;
        end
    end

`ifdef VADDSUB_MASK_EN
    logic [NBYTES-1:0] s1_vm;
    logic [VLEN_P-1:0] s1_vd;
    logic [NBYTES-1:0] byte_en, en8, en16, en32;

    // Spread each element's mask bit across the bytes of that element for every sew.
    for (genvar j = 0; j < NBYTES; j++) begin : g_byte
        assign en8[j]  = s1_vm[j];
        assign en16[j] = s1_vm[j/2];
        assign en32[j] = s1_vm[j/4];
        assign merged[j*8 +: 8] = byte_en[j] ? add_sum[j*8 +: 8] : s1_vd[j*8 +: 8];
    end

    assign byte_en = s1_sew_32 ? en32 : (s1_sew_16_32 ? en16 : en8);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vm <= '0;
            s1_vd <= '0;
        end else if (s1_ready && in_valid) begin
            s1_vm <= in_vm;
            s1_vd <= in_vd;
        end
    end
`else
    assign merged = add_sum;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid     <= 1'b0;
            s1_ctrl      <= 1'b0;
            s1_sew_16_32 <= 1'b0;
            s1_sew_32    <= 1'b0;
            s1_err       <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ctrl      <= dec_ctrl;
                s1_sew_16_32 <= dec_sew_16_32;
                s1_sew_32    <= dec_sew_32;
                s1_err       <= dec_err;
                s1_a         <= dec_a;
                s1_b         <= dec_b;
            end
        end
    end

    // The adder sees nothing unless S1 holds a live request.
    assign add_ctrl      = s1_valid & s1_ctrl;
    assign add_sew_16_32 = s1_valid & s1_sew_16_32;
    assign add_sew_32    = s1_valid & s1_sew_32;
    assign add_a         = s1_valid ? s1_a : '0;
    assign add_b         = s1_valid ? s1_b : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_err ? '0 : merged;
                s2_err  <= s1_err;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (s2_valid && out_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

endmodule

// File: tb/tb_vaddsub_issue.sv
// Directed bench for vaddsub_issue; models the external adder and checks hand-computed results.
module tb_vaddsub_issue;

    localparam int VLEN = 128;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [1:0]      in_op;
    logic [2:0]      in_sew;
    logic [VLEN-1:0] in_vs1, in_vs2;
`ifdef VADDSUB_MASK_EN
    logic [VLEN/8-1:0] in_vm;
    logic [VLEN-1:0]   in_vd;
`endif
    logic            add_ctrl, add_sew_16_32, add_sew_32;
    logic [VLEN-1:0] add_a, add_b, add_sum;
    logic            out_valid, out_ready, out_err;
    logic [VLEN-1:0] out_data;
    logic [15:0]     op_count;

    int check_count = 0;
    int error_count = 0;

    vaddsub_issue #(.VLEN_P(VLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sew(in_sew),
        .in_vs1(in_vs1), .in_vs2(in_vs2),
`ifdef VADDSUB_MASK_EN
        .in_vm(in_vm), .in_vd(in_vd),
`endif
        .add_ctrl(add_ctrl), .add_sew_16_32(add_sew_16_32), .add_sew_32(add_sew_32),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference lane-wise adder/subtractor standing in for the downstream datapath.
    always_comb begin
        add_sum = '0;
        if (add_sew_32) begin
            for (int i = 0; i < VLEN/32; i++)
                add_sum[i*32 +: 32] = add_ctrl ? add_a[i*32 +: 32] - add_b[i*32 +: 32]
                                               : add_a[i*32 +: 32] + add_b[i*32 +: 32];
        end else if (add_sew_16_32) begin
            for (int i = 0; i < VLEN/16; i++)
                add_sum[i*16 +: 16] = add_ctrl ? add_a[i*16 +: 16] - add_b[i*16 +: 16]
                                               : add_a[i*16 +: 16] + add_b[i*16 +: 16];
        end else begin
            for (int i = 0; i < VLEN/8; i++)
                add_sum[i*8 +: 8] = add_ctrl ? add_a[i*8 +: 8] - add_b[i*8 +: 8]
                                             : add_a[i*8 +: 8] + add_b[i*8 +: 8];
        end
    end

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [2:0] sew,
                                 input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2);
        in_valid = valid;
        in_op    = op;
        in_sew   = sew;
        in_vs1   = vs1;
        in_vs2   = vs2;
    endtask

    // One request with no backpressure: accept, result visible one edge later, then handed off.
    task automatic runSingle(input string tag, input logic [1:0] op, input logic [2:0] sew,
                             input logic [VLEN-1:0] vs1, input logic [VLEN-1:0] vs2,
                             input logic [VLEN-1:0] exp_data, input logic exp_err,
                             input logic [15:0] exp_count);
        out_ready = 1'b1;
        applyStimulus(1'b1, op, sew, vs1, vs2);
        step();
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        checkOutput({tag, "_early_valid"}, VLEN'(out_valid), VLEN'(1'b0));
        step();
        checkOutput({tag, "_valid"}, VLEN'(out_valid), VLEN'(1'b1));
        checkOutput({tag, "_data"}, out_data, exp_data);
        checkOutput({tag, "_err"}, VLEN'(out_err), VLEN'(exp_err));
        step();
        checkOutput({tag, "_count"}, VLEN'(op_count), VLEN'(exp_count));
        checkOutput({tag, "_drained"}, VLEN'(out_valid), VLEN'(1'b0));
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
`ifdef VADDSUB_MASK_EN
        in_vm = '1;
        in_vd = '0;
`endif
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        #1;
        checkOutput("rst_out_valid", VLEN'(out_valid), VLEN'(1'b0));
        checkOutput("rst_op_count", VLEN'(op_count), VLEN'(16'h0));
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_add_a", add_a, '0);
        #12;
        reset = 1'b0;
        step();
        checkOutput("post_rst_in_ready", VLEN'(in_ready), VLEN'(1'b1));

        // vadd sew=8, then check what S1 presents to the adder mid-flight
        out_ready = 1'b1;
        applyStimulus(1'b1, 2'b00, 3'b000, {16{8'h01}}, {16{8'h7F}});
        step();
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        checkOutput("vadd8_add_a", add_a, {16{8'h7F}});
        checkOutput("vadd8_add_b", add_b, {16{8'h01}});
        checkOutput("vadd8_sew", VLEN'({add_sew_32, add_sew_16_32, add_ctrl}), VLEN'(3'b000));
        checkOutput("vadd8_early_valid", VLEN'(out_valid), VLEN'(1'b0));
        step();
        checkOutput("vadd8_valid", VLEN'(out_valid), VLEN'(1'b1));
        checkOutput("vadd8_data", out_data, {16{8'h80}});
        checkOutput("vadd8_err", VLEN'(out_err), VLEN'(1'b0));
        checkOutput("vadd8_add_idle", add_a, '0);
        step();
        checkOutput("vadd8_count", VLEN'(op_count), VLEN'(16'd1));

        runSingle("vsub32", 2'b01, 3'b010, {4{32'h1}}, {4{32'h0}}, {4{32'hFFFF_FFFF}}, 1'b0, 16'd2);
        runSingle("vrsub32", 2'b10, 3'b010, {4{32'h1}}, {4{32'h0}}, {4{32'h0000_0001}}, 1'b0, 16'd3);
        runSingle("bad_sew", 2'b00, 3'b011, {4{32'h1234_5678}}, {4{32'h1111_1111}}, '0, 1'b1, 16'd4);
        runSingle("vadd16", 2'b00, 3'b001, {8{16'h0001}}, {8{16'h1234}}, {8{16'h1235}}, 1'b0, 16'd5);
        runSingle("bad_op", 2'b11, 3'b000, {16{8'h11}}, {16{8'h22}}, '0, 1'b1, 16'd6);
        runSingle("vsub16_borrow", 2'b01, 3'b001, {8{16'h0001}}, {8{16'h0100}}, {8{16'h00FF}}, 1'b0, 16'd7);

        // Backpressure: three back-to-back requests against a stalled sink
        reset = 1'b1;
        #2;
        reset = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 3'b000, {16{8'h01}}, {16{8'h10}});
        step();
        checkOutput("bp_ready_after_1", VLEN'(in_ready), VLEN'(1'b1));
        applyStimulus(1'b1, 2'b01, 3'b001, {8{16'h0001}}, {8{16'h0100}});
        step();
        checkOutput("bp_ready_after_2", VLEN'(in_ready), VLEN'(1'b0));
        applyStimulus(1'b1, 2'b10, 3'b010, {4{32'd5}}, {4{32'd3}});
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("bp_hold_ready", VLEN'(in_ready), VLEN'(1'b0));
            checkOutput("bp_hold_data", out_data, {16{8'h11}});
            checkOutput("bp_hold_valid", VLEN'(out_valid), VLEN'(1'b1));
        end
        checkOutput("bp_hold_count", VLEN'(op_count), VLEN'(16'd0));
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_release", VLEN'(in_ready), VLEN'(1'b1));
        step();
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        checkOutput("bp_second_data", out_data, {8{16'h00FF}});
        step();
        checkOutput("bp_third_data", out_data, {4{32'd2}});
        step();
        checkOutput("bp_count", VLEN'(op_count), VLEN'(16'd3));
        checkOutput("bp_drained", VLEN'(out_valid), VLEN'(1'b0));

        // Reset with both stages occupied
        out_ready = 1'b0;
        applyStimulus(1'b1, 2'b00, 3'b000, {16{8'h01}}, {16{8'h02}});
        step();
        step();
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        checkOutput("mid_full_valid", VLEN'(out_valid), VLEN'(1'b1));
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", VLEN'(out_valid), VLEN'(1'b0));
        checkOutput("mid_rst_count", VLEN'(op_count), VLEN'(16'd0));
        checkOutput("mid_rst_add_a", add_a, '0);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        checkOutput("mid_rst_in_ready", VLEN'(in_ready), VLEN'(1'b1));
        checkOutput("mid_rst_no_ghost", VLEN'(out_valid), VLEN'(1'b0));
        step();
        checkOutput("mid_rst_no_ghost2", VLEN'(out_valid), VLEN'(1'b0));

`ifdef VADDSUB_MASK_EN
        in_vm = 16'h5555;
        in_vd = {8{16'hAAAA}};
        runSingle("mask16", 2'b00, 3'b001, {8{16'h0002}}, {8{16'h0100}},
                  {4{16'hAAAA, 16'h0102}}, 1'b0, 16'd1);
        in_vm = '1;
        in_vd = '0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
`endif

        // Stream 65537 requests at full rate so op_count wraps through 0xFFFF
        out_ready = 1'b1;
        applyStimulus(1'b1, 2'b00, 3'b010, {4{32'h1}}, {4{32'h7}});
        for (int i = 0; i < 65537; i++) step();
        checkOutput("wrap_ffff", VLEN'(op_count), VLEN'(16'hFFFF));
        checkOutput("stream_data", out_data, {4{32'h8}});
        applyStimulus(1'b0, 2'b00, 3'b000, '0, '0);
        step();
        checkOutput("wrap_zero", VLEN'(op_count), VLEN'(16'h0000));
        step();
        checkOutput("wrap_one", VLEN'(op_count), VLEN'(16'h0001));
        checkOutput("wrap_drained", VLEN'(out_valid), VLEN'(1'b0));

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
